// File: rtl/mac_learning_lut_if.sv
// Lookup request/result bundle between the parser and the MAC learning table.
// The master issues requests and the slave returns results.
interface mac_learning_lut_if #(
  parameter int NUM_PORTS = 8
);
  logic                 lookup_req;
  logic                 lookup_ready;
  logic [47:0]          lookup_dst_mac;
  logic [47:0]          lookup_src_mac;
  logic [NUM_PORTS-1:0] lookup_src_port;
  logic                 lookup_done;
  logic [NUM_PORTS-1:0] dst_ports;
  logic                 lut_hit;
  logic                 lut_miss;

  modport master (
    output lookup_req,
    output lookup_dst_mac,
    output lookup_src_mac,
    output lookup_src_port,
    input  lookup_ready,
    input  lookup_done,
    input  dst_ports,
    input  lut_hit,
    input  lut_miss
  );

  modport slave (
    input  lookup_req,
    input  lookup_dst_mac,
    input  lookup_src_mac,
    input  lookup_src_port,
    output lookup_ready,
    output lookup_done,
    output dst_ports,
    output lut_hit,
    output lut_miss
  );
endinterface

// File: rtl/mac_learning_lut.sv
// Learning-switch MAC table: sequential search, forward, learn.
// Optional entry aging is enabled with MAC_LUT_AGING_EN.
module mac_learning_lut #(
  parameter int                   LUT_DEPTH     = 16,
  parameter int                   NUM_PORTS     = 8,
  parameter logic [NUM_PORTS-1:0] MAC_PORT_MASK = 8'h55,
  parameter int                   AGE_PERIOD    = 1000000
) (
  input logic              axi_aclk,
  input logic              axi_resetn,
  mac_learning_lut_if.slave lut
);

  localparam int IW = $clog2(LUT_DEPTH);

  if (LUT_DEPTH < 2 || (LUT_DEPTH & (LUT_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("LUT_DEPTH must be a power of 2, at least 2");
  end
  if (AGE_PERIOD < 1) begin : g_age_chk
    $error("AGE_PERIOD must be positive");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESOLVE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]        idx;
  logic [IW-1:0]        rep_ptr;
  logic [47:0]          dst_mac;
  logic [47:0]          src_mac;
  logic [NUM_PORTS-1:0] src_port;

  logic                 dst_found;
  logic                 src_found;
  logic                 free_found;
  logic [NUM_PORTS-1:0] dst_port;
  logic [IW-1:0]        src_idx;
  logic [IW-1:0]        free_idx;

  logic [LUT_DEPTH-1:0] ent_valid;
  logic [47:0]          ent_mac  [LUT_DEPTH];
  logic [NUM_PORTS-1:0] ent_port [LUT_DEPTH];

  logic                 accept;
  logic                 searching;
  logic                 resolve;
  logic                 cur_valid;
  logic                 dst_match;
  logic                 src_match;
  logic                 uni_hit;
  logic [NUM_PORTS-1:0] fwd_ports;
  logic                 learn_en;
  logic                 rep_adv;
  logic [IW-1:0]        learn_idx;

  assign accept    = (state == IDLE) && lut.lookup_req;
  assign searching = (state == SEARCH);
  assign resolve   = (state == RESOLVE);
  assign cur_valid = ent_valid[idx];
  assign dst_match = cur_valid && (ent_mac[idx] == dst_mac);
  assign src_match = cur_valid && (ent_mac[idx] == src_mac);

  assign uni_hit   = !dst_mac[40] && dst_found;
  assign fwd_ports = uni_hit ? (dst_port & ~src_port)
                             : (MAC_PORT_MASK & ~src_port);

  assign learn_en  = resolve && !src_mac[40];
  assign rep_adv   = learn_en && !src_found && !free_found;
  assign learn_idx = src_found  ? src_idx  :
                     free_found ? free_idx : rep_ptr;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (lut.lookup_req) state_nxt = SEARCH;
      SEARCH:  if (idx == IW'(LUT_DEPTH - 1)) state_nxt = RESOLVE;
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Search bookkeeping: only the first match / first hole is kept.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      idx        <= '0;
      dst_mac    <= '0;
      src_mac    <= '0;
      src_port   <= '0;
      dst_found  <= 1'b0;
      src_found  <= 1'b0;
      free_found <= 1'b0;
      dst_port   <= '0;
      src_idx    <= '0;
      free_idx   <= '0;
    end else if (accept) begin
      idx        <= '0;
      dst_mac    <= lut.lookup_dst_mac;
      src_mac    <= lut.lookup_src_mac;
      src_port   <= lut.lookup_src_port;
      dst_found  <= 1'b0;
      src_found  <= 1'b0;
      free_found <= 1'b0;
    end else if (searching) begin
      idx <= idx + 1'b1;
      if (dst_match && !dst_found) begin
        dst_found <= 1'b1;
        dst_port  <= ent_port[idx];
      end
      if (src_match && !src_found) begin
        src_found <= 1'b1;
        src_idx   <= idx;
      end
      if (!cur_valid && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
    end
  end

`ifdef MAC_LUT_AGING_EN
  logic [31:0]          age_cnt;
  logic                 sweep;
  logic [LUT_DEPTH-1:0] ent_age;

  assign sweep = (age_cnt == 32'(AGE_PERIOD - 1));

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) age_cnt <= '0;
    else if (sweep)  age_cnt <= '0;
    else             age_cnt <= age_cnt + 32'd1;
  end
`endif

  // Table write: the learn is ordered after the sweep so it wins its entry.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      ent_valid <= '0;
      rep_ptr   <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        ent_mac[i]  <= '0;
        ent_port[i] <= '0;
      end
`ifdef MAC_LUT_AGING_EN
      ent_age <= '0;
`endif
    end else begin
`ifdef MAC_LUT_AGING_EN
      if (sweep) begin
        ent_valid <= ent_valid & ent_age;
        ent_age   <= '0;
      end
      if (learn_en) ent_age[learn_idx] <= 1'b1;
`endif
      if (learn_en) begin
        ent_valid[learn_idx] <= 1'b1;
        ent_mac[learn_idx]   <= src_mac;
        ent_port[learn_idx]  <= src_port;
      end
      if (rep_adv) rep_ptr <= rep_ptr + 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      lut.lookup_ready <= 1'b1;
      lut.lookup_done  <= 1'b0;
      lut.lut_hit      <= 1'b0;
      lut.lut_miss     <= 1'b0;
      lut.dst_ports    <= '0;
    end else begin
      lut.lookup_ready <= (state_nxt == IDLE);
      lut.lookup_done  <= resolve;
      lut.lut_hit      <= resolve && uni_hit;
      lut.lut_miss     <= resolve && !uni_hit;
      if (resolve) lut.dst_ports <= fwd_ports;
    end
  end

endmodule
